// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: NOP encoding, base opcodes and the IF/ID record.
package pipeline_pkg;

    // Field widths of the IF/ID record; fetch_stage defaults its parameters to these.
    localparam int IF_PC_W  = 9;
    localparam int IF_INS_W = 32;

    // addi x0, x0, 0 -- harmless I-type write to x0, used as the bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Base RV32I major opcodes (bits [6:0]), also used by the control unit.
    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [IF_PC_W-1:0]  pc;
        logic [IF_INS_W-1:0] instr;
        logic                valid;
    } if_id_t;

    // Reset / flush value of the IF/ID register.
    localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: IF_INS_W'(NOP_INSTR), valid: 1'b0};

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC selection: reset > branch redirect > stall > +4.
module pc_reg
    import pipeline_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            i_reset_n,
    input  logic            i_stall,
    input  logic            i_branch_taken,
    input  logic [PC_W-1:0] i_branch_target,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_pc_next;

    // Sequential increment wraps silently at 2^PC_W.
    assign w_pc_plus4 = r_pc + PC_W'(4);

    // Next-PC mux; redirect targets are forced word-aligned.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (i_branch_taken)
            w_pc_next = {i_branch_target[PC_W-1:2], 2'b00};
        else if (i_stall)
            w_pc_next = r_pc;
    end

    // PC register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!i_reset_n)
            r_pc <= RESET_PC;
        else
            r_pc <= w_pc_next;
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem addressing, IF/ID register and fetch/bubble counters.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int              PC_W     = IF_PC_W,
    parameter int              INS_W    = IF_INS_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    output logic [PC_W-3:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    output logic [PC_W-1:0]  if_pc,
    output logic [INS_W-1:0] if_instr,
    output logic [6:0]       if_opcode,
    output logic             if_valid,
    output logic [31:0]      fetch_count,
    output logic [31:0]      bubble_count
);

    logic [PC_W-1:0] w_pc;
    if_id_t          r_if_id;
    logic [31:0]     r_fetch_count;
    logic [31:0]     r_bubble_count;

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .i_reset_n       (reset),
        .i_stall         (stall),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .o_pc            (w_pc)
    );

    assign imem_addr = w_pc[PC_W-1:2];

    // IF/ID register: a redirect flushes to a bubble even if stall is also raised.
    always_ff @(posedge clk) begin
        if (!reset)
            r_if_id <= IF_ID_BUBBLE;
        else if (branch_taken)
            r_if_id <= IF_ID_BUBBLE;
        else if (!stall)
            r_if_id <= '{pc: IF_PC_W'(w_pc), instr: IF_INS_W'(imem_rdata), valid: 1'b1};
    end

    // Retired-fetch statistics; both wrap at 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_count  <= '0;
            r_bubble_count <= '0;
        end else if (branch_taken) begin
            r_bubble_count <= r_bubble_count + 32'd1;
        end else if (!stall) begin
            r_fetch_count  <= r_fetch_count + 32'd1;
        end
    end

    assign if_pc        = PC_W'(r_if_id.pc);
    assign if_instr     = INS_W'(r_if_id.instr);
    assign if_opcode    = r_if_id.instr[6:0];
    assign if_valid     = r_if_id.valid;
    assign fetch_count  = r_fetch_count;
    assign bubble_count = r_bubble_count;

endmodule
